// File: rtl/prog_loader.sv
// prog_loader: streams a program image from a host valid/ready interface
// into the FSM instruction memory programming port, INPUT_WIDTH bits per
// shift, MSB of the image first. Holds the FSM core halted until a complete
// image has been loaded.
module prog_loader #(
    parameter int INPUT_WIDTH = 1,
    parameter int IN_WIDTH    = 8,
    parameter int MEM_WIDTH   = 131
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data,
    output logic                   in_ready,
    output logic                   prog_enable,
    output logic [INPUT_WIDTH-1:0] prog_data,
    output logic                   core_hold,
    output logic                   busy,
    output logic                   loaded,
    output logic                   done
);

    // Chunks per host word and counter widths.
    localparam int CHUNKS = IN_WIDTH / INPUT_WIDTH;
    localparam int BITS_W = $clog2(MEM_WIDTH + 1);
    localparam int CNT_W  = $clog2(CHUNKS + 1);

    localparam logic [BITS_W-1:0]      BITS_FULL  = BITS_W'(MEM_WIDTH);
    localparam logic [BITS_W-1:0]      BITS_STEP  = BITS_W'(INPUT_WIDTH);
    localparam logic [BITS_W-1:0]      BITS_ZERO  = {BITS_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_FULL   = CNT_W'(CHUNKS);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [IN_WIDTH-1:0]    WORD_ZERO  = {IN_WIDTH{1'b0}};
    localparam logic [INPUT_WIDTH-1:0] CHUNK_ZERO = {INPUT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Current-state registers.
    state_t              state_r;
    logic [BITS_W-1:0]   bits_left_r;
    logic [CNT_W-1:0]    chunk_cnt_r;
    logic [IN_WIDTH-1:0] word_buf_r;

    // Next-state values.
    state_t                 state_s;
    logic [BITS_W-1:0]      bits_left_s;
    logic [CNT_W-1:0]       chunk_cnt_s;
    logic [IN_WIDTH-1:0]    word_buf_s;
    logic                   loaded_s;
    logic [INPUT_WIDTH-1:0] prog_data_s;

    // Next-state logic: abort overrides everything, including a coincident start.
    always_comb begin
        state_s     = state_r;
        bits_left_s = bits_left_r;
        chunk_cnt_s = chunk_cnt_r;
        word_buf_s  = word_buf_r;
        loaded_s    = loaded;

        if (abort) begin
            // Partially shifted memory contents are left untouched; the image
            // is simply no longer considered valid.
            state_s     = ST_IDLE;
            bits_left_s = BITS_ZERO;
            loaded_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bits_left_s = BITS_FULL;
                        loaded_s    = 1'b0;
                        state_s     = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone
                    // completes the handshake.
                    if (in_valid) begin
                        word_buf_s  = in_data;
                        chunk_cnt_s = CNT_FULL;
                        state_s     = ST_SHIFT;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    word_buf_s  = word_buf_r << INPUT_WIDTH;
                    bits_left_s = bits_left_r - BITS_STEP;
                    chunk_cnt_s = chunk_cnt_r - CNT_ONE;
                    // The image end may fall mid-word; leftover low bits of
                    // the final word are dropped.
                    if (bits_left_r == BITS_STEP) begin
                        state_s  = ST_DONE;
                        loaded_s = 1'b1;
                    end else if (chunk_cnt_r == CNT_ONE) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s     = ST_IDLE;
                    bits_left_s = BITS_ZERO;
                    loaded_s    = 1'b0;
                end
            endcase
        end
    end

    // Chunk presented to the memory in the next cycle; zero when not shifting.
    always_comb begin
        prog_data_s = CHUNK_ZERO;
        if (state_s == ST_SHIFT) begin
            prog_data_s = word_buf_s[IN_WIDTH-1 -: INPUT_WIDTH];
        end else begin
            prog_data_s = CHUNK_ZERO;
        end
    end

    // State registers and registered outputs, derived from the next state so
    // every output is aligned with the state it describes.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bits_left_r <= BITS_ZERO;
            chunk_cnt_r <= CNT_ZERO;
            word_buf_r  <= WORD_ZERO;
            loaded      <= 1'b0;
            in_ready    <= 1'b0;
            prog_enable <= 1'b0;
            prog_data   <= CHUNK_ZERO;
            done        <= 1'b0;
            busy        <= 1'b0;
            core_hold   <= 1'b1;
        end else begin
            state_r     <= state_s;
            bits_left_r <= bits_left_s;
            chunk_cnt_r <= chunk_cnt_s;
            word_buf_r  <= word_buf_s;
            loaded      <= loaded_s;
            in_ready    <= (state_s == ST_LOAD);
            prog_enable <= (state_s == ST_SHIFT);
            prog_data   <= prog_data_s;
            done        <= (state_s == ST_DONE);
            busy        <= (state_s != ST_IDLE);
            core_hold   <= (state_s != ST_IDLE) | ~loaded_s;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven load scenarios on the default
// configuration, plus hand-written sequences for reset, idle abort/start and
// a narrow two-bit-per-shift configuration.
module tb_prog_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst;
    // Default-parameter instance.
    logic       start_a, abort_a, in_valid_a;
    logic [7:0] in_data_a;
    logic       in_ready_a, prog_enable_a, core_hold_a, busy_a, loaded_a, done_a;
    logic [0:0] prog_data_a;
    // INPUT_WIDTH=2, MEM_WIDTH=12 instance.
    logic       start_b, abort_b, in_valid_b;
    logic [7:0] in_data_b;
    logic       in_ready_b, prog_enable_b, core_hold_b, busy_b, loaded_b, done_b;
    logic [1:0] prog_data_b;

    prog_loader dut_a (
        .clock(clock), .rst(rst), .start(start_a), .abort(abort_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .prog_enable(prog_enable_a), .prog_data(prog_data_a),
        .core_hold(core_hold_a), .busy(busy_a), .loaded(loaded_a), .done(done_a)
    );

    prog_loader #(.INPUT_WIDTH(2), .IN_WIDTH(8), .MEM_WIDTH(12)) dut_b (
        .clock(clock), .rst(rst), .start(start_b), .abort(abort_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .prog_enable(prog_enable_b), .prog_data(prog_data_b),
        .core_hold(core_hold_b), .busy(busy_b), .loaded(loaded_b), .done(done_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int period;      // in_valid high when cycle % period == 0
        int start_mid;   // pulse start during SHIFT and during DONE
        int abort_at;    // abort after this many shifts (0 = never)
        int exp_shifts;
        int exp_accepts;
        int exp_done_cyc; // 0 = no done expected
    } scen_t;

    scen_t tbl [5];

    initial begin
        int cyc, shifts, acc, done_cnt, done_cyc, bad_bits, viol, fin;
        logic [7:0] pat;
        int exp_b [6];

        pat = 8'hA5;
        exp_b = '{3, 0, 0, 3, 2, 1};
        // Done cycle with 1-of-3 valid: accepts land on cycles 3,12,...,147,
        // three shifts follow, done on 151.
        tbl[0] = '{1, 0, 0,  131, 17, 149};
        tbl[1] = '{3, 0, 0,  131, 17, 151};
        tbl[2] = '{1, 0, 40, 40,  5,  0};
        tbl[3] = '{1, 0, 0,  131, 17, 149};
        tbl[4] = '{1, 1, 0,  131, 17, 149};

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'hA5;
        start_b = 1'b0; abort_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset / idle state.
        check("rst_core_hold",   core_hold_a,   1);
        check("rst_loaded",      loaded_a,      0);
        check("rst_busy",        busy_a,        0);
        check("rst_in_ready",    in_ready_a,    0);
        check("rst_prog_enable", prog_enable_a, 0);
        check("rst_prog_data",   prog_data_a,   0);
        check("rst_done",        done_a,        0);

        // Table-driven load scenarios on the default instance.
        for (int i = 0; i < 5; i++) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            cyc = 1; shifts = 0; acc = 0; done_cnt = 0; done_cyc = 0;
            bad_bits = 0; viol = 0; fin = 0;
            while (fin == 0 && cyc < 1000) begin
                in_valid_a = (cyc % tbl[i].period == 0);
                if (cyc == 1) begin
                    check($sformatf("s%0d_loaded_cleared", i), loaded_a, 0);
                    check($sformatf("s%0d_busy", i), busy_a, 1);
                    check($sformatf("s%0d_hold", i), core_hold_a, 1);
                end
                if (in_valid_a && in_ready_a) acc++;
                if (!prog_enable_a && prog_data_a !== 1'b0) viol++;
                if (in_ready_a && (prog_enable_a || done_a)) viol++;
                if (prog_enable_a) begin
                    if (prog_data_a !== pat[7 - (shifts % 8)]) bad_bits++;
                    shifts++;
                    if (tbl[i].start_mid != 0 && shifts == 50) start_a = 1'b1;
                end
                if (done_a) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (tbl[i].start_mid != 0) start_a = 1'b1;
                    fin = 1;
                end
                if (tbl[i].abort_at != 0 && shifts == tbl[i].abort_at) begin
                    abort_a = 1'b1;
                    fin = 1;
                end
                tick();
                start_a = 1'b0;
                abort_a = 1'b0;
                cyc++;
            end
            in_valid_a = 1'b0;
            check($sformatf("s%0d_timeout", i), fin, 1);
            check($sformatf("s%0d_shifts", i), shifts, tbl[i].exp_shifts);
            check($sformatf("s%0d_accepts", i), acc, tbl[i].exp_accepts);
            check($sformatf("s%0d_data_stream", i), bad_bits, 0);
            check($sformatf("s%0d_handshake_rules", i), viol, 0);
            check($sformatf("s%0d_done_count", i), done_cnt, (tbl[i].exp_done_cyc != 0) ? 1 : 0);
            if (tbl[i].exp_done_cyc != 0)
                check($sformatf("s%0d_done_cycle", i), done_cyc, tbl[i].exp_done_cyc);
            check($sformatf("s%0d_post_busy", i), busy_a, 0);
            check($sformatf("s%0d_post_enable", i), prog_enable_a, 0);
            check($sformatf("s%0d_post_loaded", i), loaded_a, (tbl[i].abort_at == 0) ? 1 : 0);
            check($sformatf("s%0d_post_hold", i), core_hold_a, (tbl[i].abort_at == 0) ? 0 : 1);
            repeat (3) tick();
            check($sformatf("s%0d_idle_busy", i), busy_a, 0);
            check($sformatf("s%0d_idle_enable", i), prog_enable_a, 0);
        end

        // Abort in IDLE clears the loaded flag.
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("idle_abort_loaded", loaded_a, 0);
        check("idle_abort_hold", core_hold_a, 1);

        // Abort and start together: abort wins, no load begins.
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        check("abort_start_busy", busy_a, 0);
        check("abort_start_ready", in_ready_a, 0);
        tick();
        check("abort_start_busy2", busy_a, 0);

        // Reset in the middle of a load.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        in_valid_a = 1'b1;
        repeat (4) tick();
        check("midload_enable_before_rst", prog_enable_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid_a = 1'b0;
        check("midload_rst_busy", busy_a, 0);
        check("midload_rst_enable", prog_enable_a, 0);
        check("midload_rst_loaded", loaded_a, 0);
        check("midload_rst_hold", core_hold_a, 1);

        // Two-bit shifts, 12-bit image from words 0xC3, 0x9F.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 1; shifts = 0; acc = 0; done_cnt = 0; done_cyc = 0;
        bad_bits = 0; viol = 0; fin = 0;
        while (fin == 0 && cyc < 200) begin
            in_valid_b = 1'b1;
            in_data_b  = (acc == 0) ? 8'hC3 : ((acc == 1) ? 8'h9F : 8'h00);
            if (in_valid_b && in_ready_b) acc++;
            if (!prog_enable_b && prog_data_b !== 2'b00) viol++;
            if (prog_enable_b) begin
                if (shifts >= 6 || prog_data_b !== exp_b[shifts % 6]) begin
                    bad_bits++;
                end
                shifts++;
            end
            if (done_b) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1;
            end
            tick();
            cyc++;
        end
        in_valid_b = 1'b0;
        check("w2_timeout", fin, 1);
        check("w2_shifts", shifts, 6);
        check("w2_accepts", acc, 2);
        check("w2_data_stream", bad_bits, 0);
        check("w2_zero_when_idle", viol, 0);
        check("w2_done_cycle", done_cyc, 9);
        check("w2_loaded", loaded_b, 1);
        check("w2_hold", core_hold_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
